// File: rtl/gate_stim_checker.sv
// Sweeps {a,b} through 00..11, waits SETTLE_CYCLES per vector, checks y against EXPECT_TT.
// Optional first-failure capture ports are enabled by defining GATE_FAIL_CAPTURE_EN.
module gate_stim_checker #(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [3:0] EXPECT_TT     = 4'b0001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [1:0] vec_idx
`ifdef GATE_FAIL_CAPTURE_EN
  ,
  output logic       fail_valid,
  output logic [1:0] fail_idx,
  output logic       fail_y
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] settle_cnt;
  logic       mismatch;
  logic [2:0] err_next;

  // Case inequality so an X/Z response is scored as a failure in simulation.
  always_comb begin
    mismatch = (y !== EXPECT_TT[vec_idx]);
    err_next = err_cnt;
    if (mismatch && (err_cnt != 3'd4)) begin
      err_next = err_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a          <= 1'b0;
      b          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= 3'd0;
      vec_idx    <= 2'd0;
      settle_cnt <= 4'd0;
`ifdef GATE_FAIL_CAPTURE_EN
      fail_valid <= 1'b0;
      fail_idx   <= 2'd0;
      fail_y     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state      <= SETTLE;
            {a, b}     <= 2'b00;
            vec_idx    <= 2'd0;
            busy       <= 1'b1;
            err_cnt    <= 3'd0;
            pass       <= 1'b0;
            settle_cnt <= 4'd0;
`ifdef GATE_FAIL_CAPTURE_EN
            fail_valid <= 1'b0;
            fail_idx   <= 2'd0;
            fail_y     <= 1'b0;
`endif
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= CHECK;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        CHECK: begin
          err_cnt <= err_next;
`ifdef GATE_FAIL_CAPTURE_EN
          if (mismatch && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_idx   <= vec_idx;
            fail_y     <= y;
          end
`endif
          if (vec_idx == 2'd3) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= (err_next == 3'd0);
          end else begin
            state      <= SETTLE;
            vec_idx    <= vec_idx + 2'd1;
            {a, b}     <= vec_idx + 2'd1;
            settle_cnt <= 4'd0;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_stim_checker.sv
// Directed bench for gate_stim_checker: default instance plus a SETTLE_CYCLES=1 instance.
module tb_gate_stim_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, start2;
  logic       y1, y2;
  logic       a1, b1, busy1, done1, pass1;
  logic [2:0] err1;
  logic [1:0] vec1;
  logic       a2, b2, busy2, done2, pass2;
  logic [2:0] err2;
  logic [1:0] vec2;
`ifdef GATE_FAIL_CAPTURE_EN
  logic       fv1, fy1, fv2, fy2;
  logic [1:0] fi1, fi2;
`endif

  int mode;     // 0: correct NOR, 1: tied 0, 2: tied 1
  logic y2_inv; // corrupts dut2's y outside its sample cycles
  int n_chk = 0;
  int n_pass = 0;
  int cyc;

  always_comb begin
    y1 = 1'b1;
    if (mode == 0) y1 = ~(a1 | b1);
    else if (mode == 1) y1 = 1'b0;
    y2 = y2_inv ? (a2 | b2) : ~(a2 | b2);
  end

  gate_stim_checker u_dut (
    .clk(clk), .rst(rst), .start(start), .y(y1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .vec_idx(vec1)
`ifdef GATE_FAIL_CAPTURE_EN
    , .fail_valid(fv1), .fail_idx(fi1), .fail_y(fy1)
`endif
  );

  gate_stim_checker #(.SETTLE_CYCLES(1)) u_dut_s1 (
    .clk(clk), .rst(rst), .start(start2), .y(y2),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2), .vec_idx(vec2)
`ifdef GATE_FAIL_CAPTURE_EN
    , .fail_valid(fv2), .fail_idx(fi2), .fail_y(fy2)
`endif
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Start in cycle 0; optional extra start pulse / reset at given cycles.
  task automatic sweep(input int mode_i, input int pulse_at, input int rst_at,
                       output int dcyc, output int dcnt);
    mode = mode_i;
    dcyc = -1;
    dcnt = 0;
    cyc = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (cyc <= 18) begin
      if (cyc == 1) begin
        chk("start_busy", int'(busy1), 1);
        chk("start_ab", int'({a1, b1}), 0);
        chk("start_vec", int'(vec1), 0);
        chk("start_err", int'(err1), 0);
        chk("start_pass", int'(pass1), 0);
      end
      if (rst_at < 0) begin
        if (cyc == 3)  chk("settle_ab_stable", int'({a1, b1}), 0);
        if (cyc == 4)  chk("ab_vec1", int'({a1, b1}), 1);
        if (cyc == 7)  chk("ab_vec2", int'({a1, b1}), 2);
        if (cyc == 10) chk("ab_vec3", int'({a1, b1}), 3);
      end
      if (rst_at > 0 && cyc == rst_at + 1) begin
        chk("rst_clear", int'({a1, b1, busy1, done1, pass1, err1, vec1}), 0);
      end
      if (done1) begin
        dcnt++;
        if (dcyc < 0) dcyc = cyc;
        chk("done_busy_low", int'(busy1), 0);
      end
      start = (cyc == pulse_at);
      rst   = (cyc == rst_at);
      step();
    end
    start = 1'b0;
    rst = 1'b0;
  endtask

  int dc, dn;

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0; mode = 0; y2_inv = 1'b0; cyc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", int'({a1, b1, busy1, done1, pass1, err1, vec1}), 0);
    chk("reset_outputs_s1", int'({a2, b2, busy2, done2, pass2, err2, vec2}), 0);
    rst = 1'b0;

    // correct NOR
    sweep(0, -1, -1, dc, dn);
    chk("nor_done_cycle", dc, 13);
    chk("nor_done_count", dn, 1);
    chk("nor_pass", int'(pass1), 1);
    chk("nor_err", int'(err1), 0);
    chk("idle_vec_hold", int'(vec1), 3);
`ifdef GATE_FAIL_CAPTURE_EN
    chk("nor_fail_valid", int'(fv1), 0);
`endif

    // y tied low: only vector 0 (expects 1) mismatches
    sweep(1, -1, -1, dc, dn);
    chk("tie0_err", int'(err1), 1);
    chk("tie0_pass", int'(pass1), 0);
`ifdef GATE_FAIL_CAPTURE_EN
    chk("tie0_fail_valid", int'(fv1), 1);
    chk("tie0_fail_idx", int'(fi1), 0);
    chk("tie0_fail_y", int'(fy1), 0);
`endif

    // y tied high: vectors 1..3 mismatch, capture keeps the first
    sweep(2, -1, -1, dc, dn);
    chk("tie1_err", int'(err1), 3);
    chk("tie1_pass", int'(pass1), 0);
    chk("tie1_done_cycle", dc, 13);
`ifdef GATE_FAIL_CAPTURE_EN
    chk("tie1_fail_valid", int'(fv1), 1);
    chk("tie1_fail_idx", int'(fi1), 1);
    chk("tie1_fail_y", int'(fy1), 1);
`endif

    // extra start at cycle 5 is ignored
    sweep(0, 5, -1, dc, dn);
    chk("restart_done_cycle", dc, 13);
    chk("restart_done_count", dn, 1);
    chk("restart_pass", int'(pass1), 1);

    // reset at cycle 6 aborts with no done pulse
    sweep(0, -1, 6, dc, dn);
    chk("abort_done_count", dn, 0);
    chk("abort_busy", int'(busy1), 0);
    sweep(0, -1, -1, dc, dn);
    chk("after_abort_done_cycle", dc, 13);
    chk("after_abort_pass", int'(pass1), 1);

    // SETTLE_CYCLES=1: y is only correct in cycles 2,4,6,8
    dc = -1; dn = 0; cyc = 0;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    while (cyc <= 14) begin
      y2_inv = (cyc % 2 == 1) && (cyc < 9);
      if (cyc >= 1 && cyc <= 8) chk("s1_vec_idx", int'(vec2), (cyc - 1) / 2);
      if (done2) begin
        dn++;
        if (dc < 0) dc = cyc;
      end
      step();
    end
    y2_inv = 1'b0;
    chk("s1_done_cycle", dc, 9);
    chk("s1_done_count", dn, 1);
    chk("s1_pass", int'(pass2), 1);
    chk("s1_err", int'(err2), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
